datawidthconv_wide_to_narrow: RTL and testbench

//  Buffers one packet of IN_W-bit stream beats (sop..eop) and replays it as OUT_W-bit word

---
 rtl/dwc_pkg.sv | 23 ++
 rtl/simple_dualportram.sv | 25 ++
 rtl/datawidthconv_wide_to_narrow.sv | 157 +++++++++++++++
 tb/tb_datawidthconv_wide_to_narrow.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dwc_pkg.sv
// Shared types and constants for the wide-to-narrow width converter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dwc_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        RD_WAIT = 2'd1,
        LOAD    = 2'd2,
        SHIFT   = 2'd3
    } state_t;

    localparam int BITS_PER_BYTE = 8;

    function automatic int ratio(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    function automatic int byte_step(input int out_w);
        return out_w / BITS_PER_BYTE;
    endfunction

endpackage

// File: rtl/simple_dualportram.sv
// One write port, one registered read port; DEPTH is log2 of the entry count.
// Latency: read data valid one clk after raddr.
// Backpressure: none; writes and reads are accepted every cycle.
module simple_dualportram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [DEPTH-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:(1<<DEPTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/datawidthconv_wide_to_narrow.sv
// Buffers one IN_W-bit packet, then replays it as OUT_W-bit addressed word writes (DWC_LSW_FIRST_EN: LSW first).
// Latency: first word 3 clk after the eop beat; one clk per word, 2-clk gap between beats.
// Backpressure: snk_ready low from eop until done; data_ready=0 holds the presented word.
module datawidthconv_wide_to_narrow
    import dwc_pkg::*;
#(
    parameter int IN_W       = 512,
    parameter int OUT_W      = 32,
    parameter int DEPTH_LOG2 = 5,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              snk_sop,
    input  logic              snk_eop,
    input  logic              snk_valid,
    input  logic [IN_W-1:0]   snk_din,
    output logic              snk_ready,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] data_addr,
    output logic [OUT_W-1:0]  data_din,
    output logic              data_we,
    input  logic              data_ready,
    output logic              done,
    output logic              overflow
);

    localparam int RATIO = ratio(IN_W, OUT_W);
    localparam int STEP  = byte_step(OUT_W);
    localparam int DW    = DEPTH_LOG2 + 1;
    localparam int KW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    generate
        if ((IN_W % OUT_W) != 0 || (OUT_W % 8) != 0) begin : g_param_check
            $error("datawidthconv_wide_to_narrow: IN_W must be a multiple of OUT_W and OUT_W a multiple of 8");
        end
    endgenerate

    state_t                state;
    logic [DW-1:0]         wcnt;
    logic [DW-1:0]         nbeats;
    logic [DEPTH_LOG2-1:0] rbeat;
    logic [KW-1:0]         k;
    logic [IN_W-1:0]       shreg;
    logic [IN_W-1:0]       shreg_nxt;
    logic [IN_W-1:0]       ram_dout;
    logic                  beat_acc;
    logic                  buf_full;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_waddr;

    function automatic logic [OUT_W-1:0] word0(input logic [IN_W-1:0] b);
`ifdef DWC_LSW_FIRST_EN
        return b[OUT_W-1:0];
`else
        return b[IN_W-1 -: OUT_W];
`endif
    endfunction

`ifdef DWC_LSW_FIRST_EN
    assign shreg_nxt = shreg >> OUT_W;
`else
    assign shreg_nxt = shreg << OUT_W;
`endif

    assign beat_acc  = snk_valid & snk_ready & (state == FILL);
    assign buf_full  = (wcnt == DW'(1 << DEPTH_LOG2));
    // A sop always lands at entry 0, even when the buffer is full.
    assign ram_we    = beat_acc & (snk_sop | ~buf_full);
    assign ram_waddr = snk_sop ? '0 : wcnt[DEPTH_LOG2-1:0];

    simple_dualportram #(
        .WIDTH (IN_W),
        .DEPTH (DEPTH_LOG2)
    ) u_buf (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (snk_din),
        .raddr (rbeat),
        .rdata (ram_dout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FILL;
            snk_ready <= 1'b1;
            data_we   <= 1'b0;
            data_addr <= '0;
            data_din  <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            wcnt      <= '0;
            nbeats    <= '0;
            rbeat     <= '0;
            k         <= '0;
            shreg     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                FILL: begin
                    if (beat_acc) begin
                        if (snk_sop) begin
                            wcnt <= DW'(1);
                        end else if (buf_full) begin
                            overflow <= 1'b1;
                        end else begin
                            wcnt <= wcnt + DW'(1);
                        end
                        if (snk_eop) begin
                            nbeats    <= snk_sop ? DW'(1) : (buf_full ? wcnt : wcnt + DW'(1));
                            data_addr <= base_addr;
                            snk_ready <= 1'b0;
                            rbeat     <= '0;
                            wcnt      <= '0;
                            state     <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shreg    <= ram_dout;
                    data_din <= word0(ram_dout);
                    data_we  <= 1'b1;
                    k        <= '0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (data_ready) begin
                        data_addr <= data_addr + ADDR_W'(STEP);
                        if (k == KW'(RATIO - 1)) begin
                            // Drop data_we between beats so no stale word is presented while reloading.
                            data_we <= 1'b0;
                            k       <= '0;
                            if ({1'b0, rbeat} == nbeats - DW'(1)) begin
                                done      <= 1'b1;
                                snk_ready <= 1'b1;
                                state     <= FILL;
                            end else begin
                                rbeat <= rbeat + DEPTH_LOG2'(1);
                                state <= RD_WAIT;
                            end
                        end else begin
                            k        <= k + KW'(1);
                            shreg    <= shreg_nxt;
                            data_din <= word0(shreg_nxt);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_datawidthconv_wide_to_narrow.sv
// Randomised and directed bench for datawidthconv_wide_to_narrow against a beat-queue model.
`timescale 1ns/1ps
module tb_datawidthconv_wide_to_narrow;

    localparam int IN_W  = 512;
    localparam int OUT_W = 32;
    localparam int DL2   = 5;
    localparam int AW    = 32;
    localparam int RATIO = IN_W / OUT_W;
    localparam int DEPTH = 1 << DL2;
    localparam int STEP  = OUT_W / 8;
    localparam int BOUND = 20000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic            snk_sop = 0, snk_eop = 0, snk_valid = 0, snk_ready;
    logic [IN_W-1:0] snk_din = '0;
    logic [AW-1:0]   base_addr = '0, data_addr;
    logic [OUT_W-1:0] data_din;
    logic            data_we, data_ready = 1'b1, done, overflow;

    datawidthconv_wide_to_narrow u_dut (
        .clk(clk), .reset(reset),
        .snk_sop(snk_sop), .snk_eop(snk_eop), .snk_valid(snk_valid), .snk_din(snk_din),
        .snk_ready(snk_ready), .base_addr(base_addr),
        .data_addr(data_addr), .data_din(data_din), .data_we(data_we),
        .data_ready(data_ready), .done(done), .overflow(overflow)
    );

    // Second instance: 128 -> 64 conversion.
    logic          sop2 = 0, eop2 = 0, valid2 = 0, ready2;
    logic [127:0]  din2 = '0;
    logic [31:0]   base2 = '0, addr2;
    logic [63:0]   dout2;
    logic          we2, dready2 = 1'b1, done2, ovf2;

    datawidthconv_wide_to_narrow #(
        .IN_W(128), .OUT_W(64), .DEPTH_LOG2(2), .ADDR_W(32)
    ) u_dut2 (
        .clk(clk), .reset(reset),
        .snk_sop(sop2), .snk_eop(eop2), .snk_valid(valid2), .snk_din(din2),
        .snk_ready(ready2), .base_addr(base2),
        .data_addr(addr2), .data_din(dout2), .data_we(we2),
        .data_ready(dready2), .done(done2), .overflow(ovf2)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [AW-1:0]    a;
        logic [OUT_W-1:0] d;
    } wr_t;

    wr_t             exp_q[$];
    logic [IN_W-1:0] pkt_q[$];
    wr_t             cw;
    logic            ovf_exp = 1'b0;
    int              done_cnt = 0, words_acc = 0;
    logic [AW-1:0]   first_a, last_a;
    logic [OUT_W-1:0] first_d, last_d;
    int              dr_mode = 0, cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] word_of(input logic [IN_W-1:0] b, input int k);
`ifdef DWC_LSW_FIRST_EN
        return b[k*OUT_W +: OUT_W];
`else
        return b[IN_W-1-k*OUT_W -: OUT_W];
`endif
    endfunction

    // Beat b, MSW-position j holds {0F-b, 00, j, 00}.
    function automatic logic [IN_W-1:0] pat(input int b);
        logic [IN_W-1:0] r;
        for (int j = 0; j < RATIO; j++) begin
            r[IN_W-1-j*OUT_W -: OUT_W] = {8'h0F - 8'(b), 8'h00, 8'(j), 8'h00};
        end
        return r;
    endfunction

    function automatic logic [IN_W-1:0] rand_beat();
        logic [IN_W-1:0] r;
        for (int j = 0; j < RATIO; j++) begin
            r[j*OUT_W +: OUT_W] = $urandom;
        end
        return r;
    endfunction

    task automatic model_accept(input logic sop, input logic eop, input logic [IN_W-1:0] din,
                                input logic [AW-1:0] base);
        if (sop) begin
            pkt_q.delete();
            pkt_q.push_back(din);
        end else if (pkt_q.size() == DEPTH) begin
            ovf_exp = 1'b1;
        end else begin
            pkt_q.push_back(din);
        end
        if (eop) begin
            foreach (pkt_q[b]) begin
                for (int k = 0; k < RATIO; k++) begin
                    wr_t w;
                    w.a = base + AW'((b * RATIO + k) * STEP);
                    w.d = word_of(pkt_q[b], k);
                    exp_q.push_back(w);
                end
            end
            pkt_q.delete();
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat was taken.
    task automatic send_beat(input logic sop, input logic eop, input logic [IN_W-1:0] din,
                             input logic [AW-1:0] base);
        int g = 0;
        snk_valid = 1'b1; snk_sop = sop; snk_eop = eop; snk_din = din; base_addr = base;
        @(negedge clk);
        while (!snk_ready && g < BOUND) begin
            @(negedge clk);
            g++;
        end
        if (!snk_ready) begin
            checks++; errors++;
            $display("FAIL beat_accept_timeout: snk_ready %0b required 1", snk_ready);
        end
        @(posedge clk);
        model_accept(sop, eop, din, base);
        #1;
        snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        while ((exp_q.size() != 0 || !snk_ready || data_we) && g < BOUND) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= BOUND) begin
            checks++; errors++;
            $display("FAIL %s_drain_timeout: %0d words pending, required 0", name, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        case (dr_mode)
            0:       data_ready = 1'b1;
            1:       data_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: data_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Compare process: every non-reset cycle against the model.
    logic            prev_stall = 1'b0, prev_done = 1'b0;
    logic [AW-1:0]   prev_a;
    logic [OUT_W-1:0] prev_d;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            check("overflow", overflow, ovf_exp);
            if (prev_stall) begin
                check("hold_we", data_we, 1'b1);
                check("hold_addr", data_addr, prev_a);
                check("hold_din", data_din, prev_d);
            end
            if (data_we) check("snk_ready_in_drain", snk_ready, 1'b0);
            if (data_we && data_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr %0h din %0h, required no write", data_addr, data_din);
                end else begin
                    cw = exp_q.pop_front();
                    check("wr_addr", data_addr, cw.a);
                    check("wr_din", data_din, cw.d);
                end
                if (words_acc == 0) begin
                    first_a = data_addr;
                    first_d = data_din;
                end
                last_a = data_addr;
                last_d = data_din;
                words_acc++;
            end
            if (done) begin
                done_cnt++;
                check("done_after_last_word", exp_q.size(), 0);
                check("done_one_cycle", prev_done, 1'b0);
            end
            prev_stall = data_we && !data_ready;
            prev_a     = data_addr;
            prev_d     = data_din;
            prev_done  = done;
        end
    end

    logic [63:0] q2[$];
    logic [31:0] qa2[$];
    int          done2_cnt = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (we2 && dready2) begin
                q2.push_back(dout2);
                qa2.push_back(addr2);
            end
            if (done2) done2_cnt++;
        end
    end

    task automatic send2(input logic sop, input logic eop, input logic [127:0] din);
        int g = 0;
        valid2 = 1'b1; sop2 = sop; eop2 = eop; din2 = din; base2 = 32'h40;
        @(negedge clk);
        while (!ready2 && g < BOUND) begin
            @(negedge clk);
            g++;
        end
        if (!ready2) begin
            checks++; errors++;
            $display("FAIL dut2_accept_timeout: ready %0b required 1", ready2);
        end
        @(posedge clk); #1;
        valid2 = 1'b0; sop2 = 1'b0; eop2 = 1'b0;
    endtask

    task automatic start_test();
        words_acc = 0;
    endtask

    logic [IN_W-1:0] dtmp;
    logic [127:0]    d2 [3];
    logic [63:0]     e2 [6];
    int              d0, n, g;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_snk_ready", snk_ready, 1'b1);
        check("rst_data_we", data_we, 1'b0);
        check("rst_data_addr", data_addr, 0);
        check("rst_data_din", data_din, 0);
        check("rst_done", done, 1'b0);
        check("rst_overflow", overflow, 1'b0);

        // 1: two beats, full-rate drain.
        start_test(); d0 = done_cnt; dr_mode = 0;
        send_beat(1'b1, 1'b0, pat(0), 32'h100);
        send_beat(1'b0, 1'b1, pat(1), 32'h100);
        wait_idle("t1");
        check("t1_words", words_acc, 32);
        check("t1_first_addr", first_a, 32'h100);
        check("t1_last_addr", last_a, 32'h17C);
`ifdef DWC_LSW_FIRST_EN
        check("t1_first_din", first_d, 32'h0F000F00);
        check("t1_last_din", last_d, 32'h0E000000);
`else
        check("t1_first_din", first_d, 32'h0F000000);
        check("t1_last_din", last_d, 32'h0E000F00);
`endif
        check("t1_done_pulses", done_cnt - d0, 1);

        // 2: single sop&eop beat.
        start_test(); d0 = done_cnt;
        dtmp = rand_beat();
        send_beat(1'b1, 1'b1, dtmp, 32'h2000);
        wait_idle("t2");
        check("t2_words", words_acc, 16);
`ifdef DWC_LSW_FIRST_EN
        check("t2_first_din", first_d, dtmp[31:0]);
`else
        check("t2_first_din", first_d, dtmp[511:480]);
`endif
        check("t2_done_pulses", done_cnt - d0, 1);

        // 3: data_ready toggling 1,0,0,1.
        start_test(); d0 = done_cnt; dr_mode = 1;
        send_beat(1'b1, 1'b0, rand_beat(), 32'h3000);
        send_beat(1'b0, 1'b0, rand_beat(), 32'h3000);
        send_beat(1'b0, 1'b1, rand_beat(), 32'h3000);
        wait_idle("t3");
        check("t3_words", words_acc, 48);
        check("t3_done_pulses", done_cnt - d0, 1);

        // 5: restart on mid-packet sop.
        start_test(); d0 = done_cnt; dr_mode = 0;
        send_beat(1'b1, 1'b0, pat(5), 32'h0);
        send_beat(1'b0, 1'b0, pat(6), 32'h0);
        send_beat(1'b1, 1'b0, pat(3), 32'h0);
        send_beat(1'b0, 1'b1, pat(4), 32'h0);
        wait_idle("t5");
        check("t5_words", words_acc, 32);
        check("t5_first_addr", first_a, 32'h0);
`ifdef DWC_LSW_FIRST_EN
        check("t5_first_din", first_d, 32'h0C000F00);
`else
        check("t5_first_din", first_d, 32'h0C000000);
`endif

        // 4: 33 beats into a 32-beat buffer.
        start_test(); d0 = done_cnt; dr_mode = 2;
        for (int i = 0; i < 33; i++) begin
            send_beat(i == 0, i == 32, rand_beat(), 32'h8000);
        end
        wait_idle("t4");
        check("t4_overflow", overflow, 1'b1);
        check("t4_words", words_acc, 512);
        check("t4_done_pulses", done_cnt - d0, 1);

        // 6: reset while the 5th word is presented.
        start_test(); dr_mode = 0;
        send_beat(1'b1, 1'b0, rand_beat(), 32'h500);
        send_beat(1'b0, 1'b1, rand_beat(), 32'h500);
        g = 0;
        while (words_acc < 4 && g < BOUND) begin
            @(posedge clk); #1;
            g++;
        end
        check("t6_reached_word5", words_acc, 4);
        reset = 1'b1;
        exp_q.delete(); pkt_q.delete(); ovf_exp = 1'b0;
        @(posedge clk); #1;
        check("t6_we_after_reset", data_we, 1'b0);
        check("t6_addr_after_reset", data_addr, 0);
        check("t6_ready_after_reset", snk_ready, 1'b1);
        check("t6_ovf_after_reset", overflow, 1'b0);
        reset = 1'b0;
        start_test(); d0 = done_cnt;
        send_beat(1'b1, 1'b1, rand_beat(), 32'h600);
        wait_idle("t6b");
        check("t6_new_words", words_acc, 16);
        check("t6_new_first_addr", first_a, 32'h600);
        check("t6_new_done", done_cnt - d0, 1);

        // Random packets with random gaps, bases and stalls.
        dr_mode = 2;
        for (int p = 0; p < 20; p++) begin
            start_test(); d0 = done_cnt;
            n = $urandom_range(1, 6);
            base_addr = $urandom;
            dtmp = '0;
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                send_beat(i == 0, i == n - 1, rand_beat(), base_addr);
            end
            wait_idle("rnd");
            check("rnd_words", words_acc, n * RATIO);
            check("rnd_done", done_cnt - d0, 1);
        end

        // 7: 128 -> 64, three beats.
        d2[0] = 128'hAAAA_0000_0000_0001_AAAA_0000_0000_0002;
        d2[1] = 128'hBBBB_0000_0000_0001_BBBB_0000_0000_0002;
        d2[2] = 128'hCCCC_0000_0000_0001_CCCC_0000_0000_0002;
`ifdef DWC_LSW_FIRST_EN
        e2 = '{64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0002,
               64'hBBBB_0000_0000_0001, 64'hCCCC_0000_0000_0002, 64'hCCCC_0000_0000_0001};
`else
        e2 = '{64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0002, 64'hBBBB_0000_0000_0001,
               64'hBBBB_0000_0000_0002, 64'hCCCC_0000_0000_0001, 64'hCCCC_0000_0000_0002};
`endif
        q2.delete(); qa2.delete(); done2_cnt = 0;
        send2(1'b1, 1'b0, d2[0]);
        send2(1'b0, 1'b0, d2[1]);
        send2(1'b0, 1'b1, d2[2]);
        g = 0;
        while (done2_cnt == 0 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        check("t7_words", q2.size(), 6);
        check("t7_done", done2_cnt, 1);
        for (int i = 0; i < 6; i++) begin
            if (i < q2.size()) begin
                check("t7_addr", qa2[i], 32'h40 + 32'(8 * i));
                check("t7_din", q2[i], e2[i]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
